spi_dac_frame_receiver: RTL and testbench
=========================================

# spi_dac_frame_receiver

Passive SPI receiver that sits on the DAC bus (SPI_SCK, SPI_MOSI, DAC_CS, DAC_CLR) and decodes the 32-bit LTC2624-style command frames sent by the DAC driver. It mirrors the DAC's internal input and output registers for channels A–D. It is used as an in-fabric DAC model for simulation and loopback self-check of the waveform generators, and as a bus monitor on hardware. All inputs are oversampled on CLK_50M. The block never drives the SPI bus.

## Interface
- DATA_W, 12, DAC code width per channel.
- FRAME_W, 32, bits per frame.
- CLK_50M  in  1  system clock, 50 MHz.
- RST_N  in  1  asynchronous active-low reset.
- SPI_SCK  in  1  SPI clock from the driver; asynchronous to CLK_50M.
- SPI_MOSI  in  1  serial data, MSB first, valid on SCK rising edge.
- DAC_CS  in  1  active-low frame select.
- DAC_CLR  in  1  active-low clear of all DAC registers.
- Va, Vb, Vc, Vd  out  DATA_W  mirrored DAC output-register values.
- last_cmd  out  4  command nibble of the last accepted frame.
- last_addr  out  4  address nibble of the last accepted frame.
- frame_valid  out  1  one-cycle pulse when a frame is accepted.
- frame_error  out  1  one-cycle pulse when a frame is rejected.

## Operation
- Synchronisation:
  - SCK, MOSI, CS and CLR each pass through a 2-FF synchroniser.
  - SCK and CS additionally go through an edge-detect register.
- Frame layout, bit 31 first: [31:24] don't care, [23:20] cmd, [19:16] addr, [15:4] data, [3:0] don't care.
- State machine:
  - IDLE → SHIFT on CS falling edge. On entry, clear the shift register and the bit counter.
  - SHIFT: on each SCK rising edge, shift = {shift[30:0], MOSI}. The bit counter is 6 bits and saturates at 63.
  - SHIFT → DECODE on CS rising edge.
  - DECODE → IDLE after exactly one cycle. The frame is applied in this cycle.
- Commands:
  - 0000: write input register n.
  - 0001: update output n from input n.
  - 0010: write input n, then update all outputs.
  - 0011: write and update n.
  - 1111: no-op. Accepted, no register change.
  - Any other command: frame_error, no change.
- Addresses:
  - 0000–0011 select channels A–D.
  - 1111 selects all four channels.
  - Any other address: frame_error, no change.
- Input registers are internal. Output registers drive Va–Vd.
- last_cmd and last_addr update only on an accepted frame.
- DAC_CLR (synchronised, low):
  - Input and output registers go to 0.
  - The FSM is forced to IDLE and any partial frame is dropped without frame_error.
  - CLR dominates a simultaneous DECODE.
- Bit-count rule: see Configuration.
- SCK edges while CS is high are ignored.
- A CS glitch (falling and rising edges with no SCK edges between them) gives bit count 0 → frame_error.

## Timing
- Reset values (RST_N low): Va–Vd = 0, last_cmd = 0, last_addr = 0, frame_valid = 0, frame_error = 0, FSM = IDLE, internal registers = 0.
- The bus is sampled on the first CLK_50M rising edge after a pin change; that edge is cycle 0.
- A SCK rise is shifted in at cycle 3. The MOSI path has the same depth, so bit alignment is preserved.
- CS rising edge:
  - Detected at cycle 3, DECODE at cycle 4.
  - Va–Vd, frame_valid and frame_error are registered at the end of cycle 4 and visible at cycle 5.
  - frame_valid and frame_error are one cycle wide and mutually exclusive.
- DAC_CLR low: registers read 0 from cycle 3.
- Input constraints:
  - SCK high and low phases ≥ 2 CLK_50M cycles each; the 12.5 MHz bus rate satisfies this.
  - CS high between frames ≥ 3 cycles.
  - Back-to-back frames that meet these constraints are all decoded.

## Configuration
- SPI_RX_STRICT_LEN_EN defined:
  - A frame is accepted only if the bit count is exactly FRAME_W.
  - Any other count → frame_error.
- SPI_RX_STRICT_LEN_EN undefined:
  - Any count ≥ FRAME_W is accepted, decoding the last 32 bits shifted (daisy-chain semantics).
  - A count < FRAME_W → frame_error.

## Structure
- Package dac_rx_pkg holds:
  - Command constants (CMD_WR_IN, CMD_UPD, CMD_WR_UPD_ALL, CMD_WR_UPD, CMD_NOP).
  - Address constants (ADDR_A … ADDR_D, ADDR_ALL).
  - FRAME_W.
  - The FSM state enum (IDLE, SHIFT, DECODE).
- Sub-module sync_edge: 2-FF synchroniser plus rise/fall pulse outputs. It has 4 instances (SCK, MOSI, CS, CLR); edge outputs are unused where not needed.

## Test plan
- Frame cmd 0011, addr 0001, data 0xABC at SCK = 12.5 MHz → Vb = 0xABC and frame_valid pulse at cycle 5 after CS rise; Va, Vc, Vd stay 0.
- Frame 0000/addr 0000/0x123, then frame 0001/addr 0000 → Va stays 0 after the first frame and reads 0x123 after the second.
- Frame 0011/addr 1111/0xFFF → Va–Vd all 0xFFF; then DAC_CLR low for 4 cycles → all 0, no frame_error.
- 31-bit frame → frame_error, no register change. 40-bit frame → frame_error with SPI_RX_STRICT_LEN_EN; accepted on the last 32 bits without it.
- Frame with addr 0101, then a frame with cmd 0110 → frame_error pulse on each; last_cmd and last_addr unchanged.
- RST_N low mid-frame (after 16 bits), released, then a full valid frame → all outputs 0 during reset; the following frame decodes correctly.

Source files
------------

// File: rtl/dac_rx_pkg.sv
// Shared definitions for the passive LTC2624-style DAC frame receiver.
// Holds frame geometry, command/address encodings, the FSM state type
// and small decode helpers used by spi_dac_frame_receiver.
// Optional build macro: SPI_RX_STRICT_LEN_EN (see spi_dac_frame_receiver).
package dac_rx_pkg;

   // DAC code width per channel and bits per command frame
   localparam int DATA_W  = 12;
   localparam int FRAME_W = 32;

   // Bit counter width; the counter saturates at its all-ones value
   localparam int CNT_W   = 6;

   // Channels A-D
   localparam int NUM_CH  = 4;

   // Command nibble, frame bits [23:20]
   localparam logic [3:0] CMD_WR_IN      = 4'b0000;
   localparam logic [3:0] CMD_UPD        = 4'b0001;
   localparam logic [3:0] CMD_WR_UPD_ALL = 4'b0010;
   localparam logic [3:0] CMD_WR_UPD     = 4'b0011;
   localparam logic [3:0] CMD_NOP        = 4'b1111;

   // Address nibble, frame bits [19:16]
   localparam logic [3:0] ADDR_A   = 4'b0000;
   localparam logic [3:0] ADDR_B   = 4'b0001;
   localparam logic [3:0] ADDR_C   = 4'b0010;
   localparam logic [3:0] ADDR_D   = 4'b0011;
   localparam logic [3:0] ADDR_ALL = 4'b1111;

   // Receiver FSM
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      DECODE = 2'd2
   } dac_rx_state_e;

   // One-hot channel select for an address nibble; zero for unused addresses
   function automatic logic [NUM_CH-1:0] addr_to_sel(input logic [3:0] addr);
      logic [NUM_CH-1:0] sel;
      sel = '0;
      case (addr)
         ADDR_A:   sel = 4'b0001;
         ADDR_B:   sel = 4'b0010;
         ADDR_C:   sel = 4'b0100;
         ADDR_D:   sel = 4'b1000;
         ADDR_ALL: sel = 4'b1111;
         default:  sel = 4'b0000;
      endcase
      return sel;
   endfunction

   // True for the five command encodings the DAC understands
   function automatic logic cmd_is_valid(input logic [3:0] cmd);
      logic ok;
      ok = 1'b0;
      case (cmd)
         CMD_WR_IN,
         CMD_UPD,
         CMD_WR_UPD_ALL,
         CMD_WR_UPD,
         CMD_NOP:  ok = 1'b1;
         default:  ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for one asynchronous pin, followed by an
// edge-detect register. The level output and the registered rise/fall
// pulses leave with the same latency, so a data pin synchronised with
// one instance stays bit-aligned with a clock pin synchronised by another.
// A pin change sampled on edge 0 shows as a pulse consumed on edge 3.
module sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic meta_q;
   logic sync_q;
   logic prev_q;
   logic rise_q;
   logic fall_q;

   // Synchronise the pin, delay once more for edge detection, register pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
         prev_q <= sync_q;
         rise_q <= sync_q & ~prev_q;
         fall_q <= ~sync_q & prev_q;
      end
   end

   assign q    = prev_q;
   assign rise = rise_q;
   assign fall = fall_q;

endmodule

// File: rtl/spi_dac_frame_receiver.sv
// Passive receiver for LTC2624-style 32-bit DAC command frames.
// Oversamples SPI_SCK / SPI_MOSI / DAC_CS / DAC_CLR on CLK_50M, shifts in
// frames while DAC_CS is low and mirrors the DAC input and output
// registers of channels A-D. Never drives the bus.
//
// Build macro SPI_RX_STRICT_LEN_EN:
//   defined   - a frame is accepted only with exactly FRAME_W bits.
//   undefined - any frame of FRAME_W bits or more is accepted and the last
//               FRAME_W bits shifted are decoded (daisy-chain behaviour).
//
// frame_valid / frame_error are single-cycle pulses, never high together,
// issued on the cycle after the DECODE state. DAC_CLR low clears the DAC
// registers and aborts any frame in progress without raising frame_error.
module spi_dac_frame_receiver
   import dac_rx_pkg::*;
(
   input  logic              CLK_50M,
   input  logic              RST_N,
   input  logic              SPI_SCK,
   input  logic              SPI_MOSI,
   input  logic              DAC_CS,
   input  logic              DAC_CLR,
   output logic [DATA_W-1:0] Va,
   output logic [DATA_W-1:0] Vb,
   output logic [DATA_W-1:0] Vc,
   output logic [DATA_W-1:0] Vd,
   output logic [3:0]        last_cmd,
   output logic [3:0]        last_addr,
   output logic              frame_valid,
   output logic              frame_error,
   output dac_rx_state_e     dbg_state
);

   // ------------------------------------------------------------------
   // Pin synchronisation
   // ------------------------------------------------------------------
   logic sck_rise;
   logic mosi_lvl;
   logic cs_rise;
   logic cs_fall;
   logic clr_n_lvl;

   logic sck_lvl_unused;
   logic sck_fall_unused;
   logic mosi_rise_unused;
   logic mosi_fall_unused;
   logic cs_lvl_unused;
   logic clr_rise_unused;
   logic clr_fall_unused;

   sync_edge u_sync_sck (
      .clk   (CLK_50M),
      .rst_n (RST_N),
      .d     (SPI_SCK),
      .q     (sck_lvl_unused),
      .rise  (sck_rise),
      .fall  (sck_fall_unused)
   );

   sync_edge u_sync_mosi (
      .clk   (CLK_50M),
      .rst_n (RST_N),
      .d     (SPI_MOSI),
      .q     (mosi_lvl),
      .rise  (mosi_rise_unused),
      .fall  (mosi_fall_unused)
   );

   sync_edge u_sync_cs (
      .clk   (CLK_50M),
      .rst_n (RST_N),
      .d     (DAC_CS),
      .q     (cs_lvl_unused),
      .rise  (cs_rise),
      .fall  (cs_fall)
   );

   sync_edge u_sync_clr (
      .clk   (CLK_50M),
      .rst_n (RST_N),
      .d     (DAC_CLR),
      .q     (clr_n_lvl),
      .rise  (clr_rise_unused),
      .fall  (clr_fall_unused)
   );

   // ------------------------------------------------------------------
   // Frame capture FSM
   // ------------------------------------------------------------------
   dac_rx_state_e        state_q;
   dac_rx_state_e        state_d;
   logic [FRAME_W-1:0]   shift_q;
   logic [FRAME_W-1:0]   shift_d;
   logic [CNT_W-1:0]     bit_cnt_q;
   logic [CNT_W-1:0]     bit_cnt_d;

   // State, shift register and bit counter
   always_ff @(posedge CLK_50M or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   // Next state: start on CS fall, shift on SCK rise, decode on CS rise; CLR aborts
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;

      case (state_q)
         IDLE: begin
            if (cs_fall) begin
               state_d   = SHIFT;
               shift_d   = '0;
               bit_cnt_d = '0;
            end
         end

         SHIFT: begin
            if (sck_rise) begin
               shift_d = {shift_q[FRAME_W-2:0], mosi_lvl};
               if (bit_cnt_q != '1) begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
            if (cs_rise) begin
               state_d = DECODE;
            end
         end

         DECODE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      if (!clr_n_lvl) begin
         state_d = IDLE;
      end
   end

   assign dbg_state = state_q;

   // ------------------------------------------------------------------
   // Frame decode
   // ------------------------------------------------------------------
   logic [3:0]        frame_cmd;
   logic [3:0]        frame_addr;
   logic [DATA_W-1:0] frame_data;
   logic [NUM_CH-1:0] frame_sel;
   logic              len_ok;
   logic              frame_ok;
   logic              unused_frame_bits;

   assign frame_cmd  = shift_q[23:20];
   assign frame_addr = shift_q[19:16];
   assign frame_data = shift_q[15:4];
   assign frame_sel  = addr_to_sel(frame_addr);

   // Padding byte and trailing nibble carry no information
   assign unused_frame_bits = ^{shift_q[31:24], shift_q[3:0]};

`ifdef SPI_RX_STRICT_LEN_EN
   assign len_ok = (bit_cnt_q == CNT_W'(FRAME_W));
`else
   assign len_ok = (bit_cnt_q >= CNT_W'(FRAME_W));
`endif

   assign frame_ok = len_ok && cmd_is_valid(frame_cmd) && (frame_sel != '0);

   // ------------------------------------------------------------------
   // Mirrored DAC registers
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] in_q  [NUM_CH];
   logic [DATA_W-1:0] in_d  [NUM_CH];
   logic [DATA_W-1:0] out_q [NUM_CH];
   logic [DATA_W-1:0] out_d [NUM_CH];
   logic [3:0]        last_cmd_q;
   logic [3:0]        last_cmd_d;
   logic [3:0]        last_addr_q;
   logic [3:0]        last_addr_d;
   logic              valid_q;
   logic              valid_d;
   logic              error_q;
   logic              error_d;

   // Apply the captured frame in DECODE; CLR wins over a concurrent decode
   always_comb begin
      in_d        = in_q;
      out_d       = out_q;
      last_cmd_d  = last_cmd_q;
      last_addr_d = last_addr_q;
      valid_d     = 1'b0;
      error_d     = 1'b0;

      if (!clr_n_lvl) begin
         for (int i = 0; i < NUM_CH; i++) begin
            in_d[i]  = '0;
            out_d[i] = '0;
         end
      end else if (state_q == DECODE) begin
         if (frame_ok) begin
            valid_d     = 1'b1;
            last_cmd_d  = frame_cmd;
            last_addr_d = frame_addr;
            for (int i = 0; i < NUM_CH; i++) begin
               case (frame_cmd)
                  CMD_WR_IN: begin
                     if (frame_sel[i]) in_d[i] = frame_data;
                  end
                  CMD_UPD: begin
                     if (frame_sel[i]) out_d[i] = in_q[i];
                  end
                  CMD_WR_UPD_ALL: begin
                     // Every output loads its input register, including the one written now
                     if (frame_sel[i]) begin
                        in_d[i]  = frame_data;
                        out_d[i] = frame_data;
                     end else begin
                        out_d[i] = in_q[i];
                     end
                  end
                  CMD_WR_UPD: begin
                     if (frame_sel[i]) begin
                        in_d[i]  = frame_data;
                        out_d[i] = frame_data;
                     end
                  end
                  default: begin
                  end
               endcase
            end
         end else begin
            error_d = 1'b1;
         end
      end
   end

   // Register the DAC mirror, the last accepted command and the status pulses
   always_ff @(posedge CLK_50M or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < NUM_CH; i++) begin
            in_q[i]  <= '0;
            out_q[i] <= '0;
         end
         last_cmd_q  <= '0;
         last_addr_q <= '0;
         valid_q     <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            in_q[i]  <= in_d[i];
            out_q[i] <= out_d[i];
         end
         last_cmd_q  <= last_cmd_d;
         last_addr_q <= last_addr_d;
         valid_q     <= valid_d;
         error_q     <= error_d;
      end
   end

   assign Va          = out_q[0];
   assign Vb          = out_q[1];
   assign Vc          = out_q[2];
   assign Vd          = out_q[3];
   assign last_cmd    = last_cmd_q;
   assign last_addr   = last_addr_q;
   assign frame_valid = valid_q;
   assign frame_error = error_q;

endmodule

// File: tb/tb_spi_dac_frame_receiver.sv
// Self-checking bench for spi_dac_frame_receiver.
// Table of frames with hand-computed DAC mirror contents, plus directed
// sequences for pulse timing, CLR during a frame and reset during a frame.
// Honours SPI_RX_STRICT_LEN_EN for the over-length frame expectation.
module tb_spi_dac_frame_receiver;
   import dac_rx_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk      = 1'b0;
   logic rst_n    = 1'b0;
   logic sck      = 1'b0;
   logic mosi     = 1'b0;
   logic cs       = 1'b1;
   logic clr      = 1'b1;

   logic [DATA_W-1:0] va, vb, vc, vd;
   logic [3:0]        last_cmd, last_addr;
   logic              frame_valid, frame_error;
   dac_rx_state_e     dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   always #10 clk = ~clk;   // 50 MHz

   spi_dac_frame_receiver dut (
      .CLK_50M     (clk),
      .RST_N       (rst_n),
      .SPI_SCK     (sck),
      .SPI_MOSI    (mosi),
      .DAC_CS      (cs),
      .DAC_CLR     (clr),
      .Va          (va),
      .Vb          (vb),
      .Vc          (vc),
      .Vd          (vd),
      .last_cmd    (last_cmd),
      .last_addr   (last_addr),
      .frame_valid (frame_valid),
      .frame_error (frame_error),
      .dbg_state   (dbg_state)
   );

   // ---------------- scoreboard ----------------
   logic [4*DATA_W-1:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_vals(input string name);
      logic [4*DATA_W-1:0] e;
      e = exp_q.pop_front();
      check(name, {va, vb, vc, vd}, e);
   endtask

   // ---------------- drivers ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // 12.5 MHz SCK: 2 cycles low with data set up, 2 cycles high
   task automatic send_bits(input logic [39:0] bits, input int nbits);
      for (int i = nbits - 1; i >= 0; i--) begin
         mosi = bits[i];
         sck  = 1'b0;
         tick(2);
         sck  = 1'b1;
         tick(2);
      end
      sck = 1'b0;
      tick(2);
   endtask

   task automatic watch(input int n, output int nv, output int ne);
      nv = 0;
      ne = 0;
      for (int i = 0; i < n; i++) begin
         tick(1);
         if (frame_valid === 1'b1) nv++;
         if (frame_error === 1'b1) ne++;
      end
   endtask

   task automatic run_frame(input logic [39:0] bits, input int nbits, output int nv, output int ne);
      cs = 1'b0;
      tick(2);
      send_bits(bits, nbits);
      cs = 1'b1;
      watch(12, nv, ne);
   endtask

   function automatic logic [39:0] fr(input logic [3:0] c, input logic [3:0] a, input logic [11:0] d);
      return {8'h00, 8'hA5, c, a, d, 4'h5};
   endfunction

   // ---------------- vector table ----------------
   typedef struct {
      logic [39:0] bits;
      int          nbits;
      bit          do_clr;
      int          exp_v;
      int          exp_e;
      logic [11:0] ea, eb, ec, ed;
      logic [3:0]  ecmd, eaddr;
   } vec_t;

   vec_t tbl[16];

`ifdef SPI_RX_STRICT_LEN_EN
   localparam logic [11:0] C_LONG = 12'h000;
`else
   localparam logic [11:0] C_LONG = 12'h456;
`endif

   initial begin
      int nv, ne, nv2, ne2;
      logic [6:0] fv, fe;
      logic [31:0] f;

      tbl[0]  = '{fr(4'h0, 4'h0, 12'h123), 32, 1'b0, 1, 0, 12'h000, 12'hABC, 12'h000, 12'h000, 4'h0, 4'h0};
      tbl[1]  = '{fr(4'h1, 4'h0, 12'h000), 32, 1'b0, 1, 0, 12'h123, 12'hABC, 12'h000, 12'h000, 4'h1, 4'h0};
      tbl[2]  = '{fr(4'h3, 4'hF, 12'hFFF), 32, 1'b0, 1, 0, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 4'h3, 4'hF};
      tbl[3]  = '{fr(4'h0, 4'h2, 12'h555), 32, 1'b0, 1, 0, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 4'h0, 4'h2};
      tbl[4]  = '{40'h0,                    0, 1'b1, 0, 0, 12'h000, 12'h000, 12'h000, 12'h000, 4'h0, 4'h2};
      tbl[5]  = '{fr(4'h1, 4'h2, 12'h000), 32, 1'b0, 1, 0, 12'h000, 12'h000, 12'h000, 12'h000, 4'h1, 4'h2};
      f = 32'(fr(4'h3, 4'h0, 12'h777));
      tbl[6]  = '{40'(f >> 1),             31, 1'b0, 0, 1, 12'h000, 12'h000, 12'h000, 12'h000, 4'h1, 4'h2};
      f = 32'(fr(4'h3, 4'h2, 12'h456));
`ifdef SPI_RX_STRICT_LEN_EN
      tbl[7]  = '{{8'h3C, f},              40, 1'b0, 0, 1, 12'h000, 12'h000, 12'h000, 12'h000, 4'h1, 4'h2};
`else
      tbl[7]  = '{{8'h3C, f},              40, 1'b0, 1, 0, 12'h000, 12'h000, 12'h456, 12'h000, 4'h3, 4'h2};
`endif
      tbl[8]  = '{fr(4'h3, 4'h5, 12'h111), 32, 1'b0, 0, 1, 12'h000, 12'h000, C_LONG, 12'h000, tbl[7].ecmd, 4'h2};
      tbl[9]  = '{fr(4'h6, 4'h0, 12'h111), 32, 1'b0, 0, 1, 12'h000, 12'h000, C_LONG, 12'h000, tbl[7].ecmd, 4'h2};
      tbl[10] = '{fr(4'hF, 4'h0, 12'h222), 32, 1'b0, 1, 0, 12'h000, 12'h000, C_LONG, 12'h000, 4'hF, 4'h0};
      tbl[11] = '{fr(4'h0, 4'h3, 12'h9A5), 32, 1'b0, 1, 0, 12'h000, 12'h000, C_LONG, 12'h000, 4'h0, 4'h3};
      tbl[12] = '{fr(4'h2, 4'h0, 12'h321), 32, 1'b0, 1, 0, 12'h321, 12'h000, C_LONG, 12'h9A5, 4'h2, 4'h0};
      tbl[13] = '{fr(4'h0, 4'h1, 12'h0F0), 32, 1'b0, 1, 0, 12'h321, 12'h000, C_LONG, 12'h9A5, 4'h0, 4'h1};
      tbl[14] = '{fr(4'h1, 4'hF, 12'h000), 32, 1'b0, 1, 0, 12'h321, 12'h0F0, C_LONG, 12'h9A5, 4'h1, 4'hF};
      tbl[15] = '{40'h0,                    0, 1'b0, 0, 1, 12'h321, 12'h0F0, C_LONG, 12'h9A5, 4'h1, 4'hF};

      // ---- reset state ----
      tick(3);
      check("rst_vals", {va, vb, vc, vd}, 48'h0);
      check("rst_last", {last_cmd, last_addr}, 8'h00);
      check("rst_pulses", {frame_valid, frame_error}, 2'b00);
      check("rst_state", 64'(dbg_state), 64'(IDLE));
      rst_n = 1'b1;
      tick(8);

      // ---- write-and-update B, exact pulse timing after CS rise ----
      cs = 1'b0;
      tick(2);
      send_bits(fr(4'h3, 4'h1, 12'hABC), 32);
      cs = 1'b1;
      for (int k = 0; k < 7; k++) begin
         tick(1);
         fv[k] = frame_valid;
         fe[k] = frame_error;
      end
      check("a_valid_timing", fv, 7'b0010000);
      check("a_error_none", fe, 7'b0000000);
      tick(6);
      check("a_vals", {va, vb, vc, vd}, {12'h000, 12'hABC, 12'h000, 12'h000});
      check("a_last", {last_cmd, last_addr}, 8'h31);

      // ---- table ----
      for (int r = 0; r < 16; r++) begin
         if (tbl[r].do_clr) begin
            clr = 1'b0;
            watch(4, nv, ne);
            clr = 1'b1;
            watch(8, nv2, ne2);
            nv = nv + nv2;
            ne = ne + ne2;
         end else begin
            run_frame(tbl[r].bits, tbl[r].nbits, nv, ne);
         end
         exp_q.push_back({tbl[r].ea, tbl[r].eb, tbl[r].ec, tbl[r].ed});
         check($sformatf("row%0d_valid", r), 64'(nv), 64'(tbl[r].exp_v));
         check($sformatf("row%0d_error", r), 64'(ne), 64'(tbl[r].exp_e));
         check_vals($sformatf("row%0d_vals", r));
         check($sformatf("row%0d_last", r), {last_cmd, last_addr}, {tbl[r].ecmd, tbl[r].eaddr});
      end

      // ---- CLR in the middle of a frame: dropped silently ----
      cs = 1'b0;
      tick(2);
      send_bits(40'(fr(4'h3, 4'hF, 12'h777) >> 16), 16);
      clr = 1'b0;
      watch(4, nv, ne);
      clr = 1'b1;
      tick(4);
      cs = 1'b1;
      watch(12, nv2, ne2);
      check("clr_mid_pulses", 64'(nv + nv2 + ne + ne2), 64'd0);
      check("clr_mid_vals", {va, vb, vc, vd}, 48'h0);

      // ---- reset in the middle of a frame ----
      run_frame(fr(4'h3, 4'hF, 12'h777), 32, nv, ne);
      check("pre_rst_vals", {va, vb, vc, vd}, {4{12'h777}});
      cs = 1'b0;
      tick(2);
      send_bits(40'(fr(4'h3, 4'h2, 12'h5A5) >> 16), 16);
      rst_n = 1'b0;
      tick(1);
      check("mid_rst_vals", {va, vb, vc, vd}, 48'h0);
      check("mid_rst_last", {last_cmd, last_addr}, 8'h00);
      check("mid_rst_state", 64'(dbg_state), 64'(IDLE));
      cs = 1'b1;
      tick(3);
      rst_n = 1'b1;
      tick(8);
      run_frame(fr(4'h3, 4'h2, 12'h5A5), 32, nv, ne);
      check("post_rst_pulses", {32'(nv), 32'(ne)}, {32'd1, 32'd0});
      check("post_rst_vals", {va, vb, vc, vd}, {12'h000, 12'h000, 12'h5A5, 12'h000});
      check("post_rst_last", {last_cmd, last_addr}, 8'h32);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
